ip_rx: RTL and testbench



---
 rtl/ip_rx.sv | 115 +++++++++++
 tb/tb_ip_rx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ip_rx.sv
// -----------------------------------------------------------------------------
// ip_rx : indicator-panel serial link receiver (oversampled shift/latch/watchdog)
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module ip_rx #(
   parameter int FRAME_BITS    = 144,
   parameter int CNT_WIDTH     = 10,
   parameter int TIMEOUT_WIDTH = 20
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic                  ser_clk,
   input  logic                  ser_data,
   input  logic                  ser_latch,
   input  logic                  ser_enable,
   output logic [FRAME_BITS-1:0] lights,
   output logic                  lights_valid,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic [7:0]            err_count
);

   localparam logic [CNT_WIDTH-1:0] c_frame_len = CNT_WIDTH'(FRAME_BITS);
   localparam logic [CNT_WIDTH-1:0] c_cnt_max   = '1;
   localparam logic [7:0]           c_err_max   = 8'hFF;

   // Stage vector layout: {enable, latch, data, clk}
   logic [3:0]                r_s1;
   logic [3:0]                r_s2;
   logic [1:0]                r_s3;    // third stage only feeds the edge detectors: {latch, clk}
   logic [FRAME_BITS-1:0]     r_shift;
   logic [CNT_WIDTH-1:0]      r_bit_cnt;
   logic [TIMEOUT_WIDTH-1:0]  r_wdog;

   logic                      w_clk_rise;
   logic                      w_latch_rise;
   logic                      w_data;
   logic                      w_enable;
   logic                      w_wdog_exp;
   logic                      w_len_ok;
   logic                      w_good;
   logic                      w_bad;
   logic [FRAME_BITS-1:0]     w_shift_next;
   logic [CNT_WIDTH-1:0]      w_cnt_next;

   assign w_clk_rise   = r_s2[0] & ~r_s3[0];
   assign w_latch_rise = r_s2[2] & ~r_s3[1];
   assign w_data       = r_s2[1];
   assign w_enable     = r_s2[3];
   assign w_wdog_exp   = (r_wdog == '1);

   // Shift and count already include any clock rise landing in the latch cycle
   always_comb begin
      w_shift_next = r_shift;
      w_cnt_next   = r_bit_cnt;
      if (w_clk_rise) begin
         w_shift_next = {r_shift[FRAME_BITS-2:0], w_data};
         if (r_bit_cnt != c_cnt_max)
            w_cnt_next = r_bit_cnt + CNT_WIDTH'(1);
      end
   end

   assign w_len_ok = (w_cnt_next == c_frame_len);
   assign w_good   = w_latch_rise & w_enable & w_len_ok;
   assign w_bad    = w_latch_rise & w_enable & ~w_len_ok;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_s1         <= '0;
         r_s2         <= '0;
         r_s3         <= '0;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_wdog       <= '0;
         lights       <= '0;
         lights_valid <= 1'b0;
         frame_done   <= 1'b0;
         frame_err    <= 1'b0;
         err_count    <= '0;
      end else begin
         r_s1 <= {ser_enable, ser_latch, ser_data, ser_clk};
         r_s2 <= r_s1;
         r_s3 <= {r_s2[2], r_s2[0]};

         r_shift    <= w_shift_next;
         // Every latch edge, even an ignored one, starts a fresh bit count
         r_bit_cnt  <= w_latch_rise ? '0 : w_cnt_next;
         frame_done <= w_good;
         frame_err  <= w_bad;

         if (w_bad && (err_count != c_err_max))
            err_count <= err_count + 8'd1;

         if (!w_enable) begin
            lights       <= '0;
            lights_valid <= 1'b0;
            r_wdog       <= '0;
         end else if (w_good) begin
            lights       <= w_shift_next;
            lights_valid <= 1'b1;
            r_wdog       <= '0;
         end else if (w_wdog_exp) begin
            lights       <= '0;
            lights_valid <= 1'b0;
         end else begin
            r_wdog <= r_wdog + TIMEOUT_WIDTH'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ip_rx.sv
// -----------------------------------------------------------------------------
// tb_ip_rx : directed self-checking bench for ip_rx (FRAME_BITS=8, TIMEOUT_WIDTH=6)
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_ip_rx;

   localparam int FB = 8;

   logic          clk_in = 1'b0;
   logic          rst_n = 1'b0;
   logic          ser_clk = 1'b0;
   logic          ser_data = 1'b0;
   logic          ser_latch = 1'b0;
   logic          ser_enable = 1'b1;
   logic [FB-1:0] lights;
   logic          lights_valid;
   logic          frame_done;
   logic          frame_err;
   logic [7:0]    err_count;

   int n_cmp = 0;
   int n_bad = 0;

   ip_rx #(.FRAME_BITS(FB), .CNT_WIDTH(4), .TIMEOUT_WIDTH(6)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .ser_clk(ser_clk), .ser_data(ser_data),
      .ser_latch(ser_latch), .ser_enable(ser_enable), .lights(lights),
      .lights_valid(lights_valid), .frame_done(frame_done), .frame_err(frame_err),
      .err_count(err_count)
   );

   always #5 clk_in = ~clk_in;

   // One serial bit: data set, clock high for 2 cycles, clock back low
   task automatic send_bit(input logic b);
      @(negedge clk_in); ser_data = b;
      @(negedge clk_in);
      @(negedge clk_in); ser_clk = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in); ser_clk = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   // Pulse latch, watch 8 cycles; dn_at is the cycle index of the first frame_done
   task automatic do_latch(output int dn, output int er, output int dn_at);
      dn = 0; er = 0; dn_at = -1;
      @(negedge clk_in); ser_latch = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk_in);
         if (frame_done === 1'b1) begin
            if (dn_at < 0) dn_at = c;
            dn++;
         end
         if (frame_err === 1'b1) er++;
         if (c == 4) ser_latch = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk_in);
      n_cmp++; if (lights !== 8'h00) begin n_bad++; $display("FAIL reset_lights got %h want 00", lights); end
      n_cmp++; if (lights_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", lights_valid); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", frame_done); end
      n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", frame_err); end
      n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL reset_errcnt got %0d want 0", err_count); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk_in);
   endtask

   task automatic test_good_frame();
      int dn, er, at;
      send_bits(16'h00A5, 8);
      do_latch(dn, er, at);
      n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL good_done_count got %0d want 1", dn); end
      n_cmp++; if (at !== 3) begin n_bad++; $display("FAIL good_done_cycle got %0d want 3", at); end
      n_cmp++; if (er !== 0) begin n_bad++; $display("FAIL good_err_count got %0d want 0", er); end
      n_cmp++; if (lights !== 8'hA5) begin n_bad++; $display("FAIL good_lights got %h want a5", lights); end
      n_cmp++; if (lights_valid !== 1'b1) begin n_bad++; $display("FAIL good_valid got %b want 1", lights_valid); end
   endtask

   task automatic test_bad_frame();
      int dn, er, at;
      send_bits(16'h0055, 7);
      do_latch(dn, er, at);
      n_cmp++; if (er !== 1) begin n_bad++; $display("FAIL short_err_pulse got %0d want 1", er); end
      n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL short_done_pulse got %0d want 0", dn); end
      n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL short_errcnt got %0d want 1", err_count); end
      n_cmp++; if (lights !== 8'hA5) begin n_bad++; $display("FAIL short_lights_kept got %h want a5", lights); end
      n_cmp++; if (lights_valid !== 1'b1) begin n_bad++; $display("FAIL short_valid_kept got %b want 1", lights_valid); end
      send_bits(16'h003C, 8);
      do_latch(dn, er, at);
      n_cmp++; if (lights !== 8'h3C) begin n_bad++; $display("FAIL next_lights got %h want 3c", lights); end
      n_cmp++; if (dn !== 1 || er !== 0) begin n_bad++; $display("FAIL next_pulses got done=%0d err=%0d want done=1 err=0", dn, er); end
   endtask

   task automatic test_watchdog();
      int dn, er, at;
      repeat (40) @(negedge clk_in);
      n_cmp++; if (lights_valid !== 1'b1 || lights !== 8'h3C) begin n_bad++; $display("FAIL wd_early got valid=%b lights=%h want 1/3c", lights_valid, lights); end
      repeat (40) @(negedge clk_in);
      n_cmp++; if (lights_valid !== 1'b0) begin n_bad++; $display("FAIL wd_valid got %b want 0", lights_valid); end
      n_cmp++; if (lights !== 8'h00) begin n_bad++; $display("FAIL wd_lights got %h want 00", lights); end
      send_bits(16'h0081, 8);
      do_latch(dn, er, at);
      n_cmp++; if (lights_valid !== 1'b1 || lights !== 8'h81) begin n_bad++; $display("FAIL wd_restore got valid=%b lights=%h want 1/81", lights_valid, lights); end
   endtask

   task automatic test_saturate();
      int dn, er, at, tot_er, tot_dn;
      tot_er = 0; tot_dn = 0;
      for (int k = 0; k < 300; k++) begin
         send_bits(16'h01A3, 9);
         do_latch(dn, er, at);
         tot_er += er; tot_dn += dn;
      end
      n_cmp++; if (tot_er !== 300) begin n_bad++; $display("FAIL sat_err_pulses got %0d want 300", tot_er); end
      n_cmp++; if (tot_dn !== 0) begin n_bad++; $display("FAIL sat_done_pulses got %0d want 0", tot_dn); end
      n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL sat_errcnt got %0d want 255", err_count); end
   endtask

   task automatic test_enable();
      int dn, er, at;
      ser_enable = 1'b0;
      repeat (4) @(negedge clk_in);
      n_cmp++; if (lights_valid !== 1'b0 || lights !== 8'h00) begin n_bad++; $display("FAIL en_blank got valid=%b lights=%h want 0/00", lights_valid, lights); end
      send_bits(16'h0055, 8);
      do_latch(dn, er, at);
      n_cmp++; if (dn !== 0 || er !== 0) begin n_bad++; $display("FAIL en_pulses got done=%0d err=%0d want 0/0", dn, er); end
      n_cmp++; if (lights !== 8'h00) begin n_bad++; $display("FAIL en_lights got %h want 00", lights); end
      ser_enable = 1'b1;
      repeat (4) @(negedge clk_in);
      send_bits(16'h0096, 8);
      do_latch(dn, er, at);
      n_cmp++; if (lights !== 8'h96 || lights_valid !== 1'b1) begin n_bad++; $display("FAIL en_reload got valid=%b lights=%h want 1/96", lights_valid, lights); end
      n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL en_reload_done got %0d want 1", dn); end
   endtask

   task automatic test_midframe_reset();
      int dn, er, at;
      send_bits(16'h000A, 4);
      @(negedge clk_in); rst_n = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_in);
      send_bits(16'h00FF, 8);
      do_latch(dn, er, at);
      n_cmp++; if (lights !== 8'hFF) begin n_bad++; $display("FAIL rst_lights got %h want ff", lights); end
      n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL rst_errcnt got %0d want 0", err_count); end
      n_cmp++; if (dn !== 1 || er !== 0) begin n_bad++; $display("FAIL rst_pulses got done=%0d err=%0d want 1/0", dn, er); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_frame();
      test_watchdog();
      test_saturate();
      test_enable();
      test_midframe_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
